// File: rtl/accum_cpu_pkg.sv
// Shared constants for the accumulator CPU: FSM state codes, opcodes and encoding helpers.
package accum_cpu_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] ST_FETCH   = 4'd1;
  localparam logic [STATE_W-1:0] ST_WAIT    = 4'd2;
  localparam logic [STATE_W-1:0] ST_OPLOAD  = 4'd3;
  localparam logic [STATE_W-1:0] ST_DECODE  = 4'd4;
  localparam logic [STATE_W-1:0] ST_EXEC1   = 4'd5;
  localparam logic [STATE_W-1:0] ST_OUT     = 4'd6;
  localparam logic [STATE_W-1:0] ST_WAIT2   = 4'd7;
  localparam logic [STATE_W-1:0] ST_OPLOAD2 = 4'd8;
  localparam logic [STATE_W-1:0] ST_EXEC2   = 4'd9;
  localparam logic [STATE_W-1:0] ST_MWAIT   = 4'd10;
  localparam logic [STATE_W-1:0] ST_MLOAD   = 4'd11;

  // Opcodes are decoded on the low OPC_W bits; the top opcode bit selects 1- vs 2-byte form.
  localparam int OPC_W = 7;

  // 1-byte forms
  localparam logic [OPC_W-1:0] OP_HLT  = 7'h00;
  localparam logic [OPC_W-1:0] OP_OUTA = 7'h01;
  localparam logic [OPC_W-1:0] OP_CLRA = 7'h02;
  localparam logic [OPC_W-1:0] OP_INCA = 7'h03;

  // 2-byte forms
  localparam logic [OPC_W-1:0] OP_LDI  = 7'h00;
  localparam logic [OPC_W-1:0] OP_LDA  = 7'h04;
  localparam logic [OPC_W-1:0] OP_STA  = 7'h05;
  localparam logic [OPC_W-1:0] OP_ADD  = 7'h06;
  localparam logic [OPC_W-1:0] OP_JMP  = 7'h08;
  localparam logic [OPC_W-1:0] OP_JZ   = 7'h09;
  localparam logic [OPC_W-1:0] OP_JC   = 7'h0A;

  // Bit index of the two-byte flag for a given data width.
  function automatic int two_byte_bit(int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/accum_cpu_alu.sv
// Combinational adder for the accumulator CPU: sum, carry out of DW bits and zero flag.
module accum_cpu_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic          carry,
  output logic          zero
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};
  assign zero         = (sum == '0);

endmodule

// File: rtl/accum_cpu_p.sv
// Parametrised accumulator CPU: fetches a program from block RAM, executes it and
// streams bytes to a UART transmitter.
module accum_cpu_p
  import accum_cpu_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 9,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] dread,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] dwrite,
  output logic          write_en,
  output logic [7:0]    tx_byte,
  output logic          transmit,
  input  logic          tx_busy,
  output logic          running,
  output logic          halted
);

  localparam int         TB        = two_byte_bit(DW);
  // Wait states hold for RD_LAT-1 cycles; with RD_LAT==1 they are skipped entirely.
  localparam bit         NO_WAIT   = (RD_LAT == 1);
  localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 2);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic [DW-1:0]      opcode_q, opcode_d;
  logic [DW-1:0]      operand_q, operand_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [AW-1:0]      raddr_q, raddr_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DW-1:0]      dwrite_q, dwrite_d;
  logic               write_en_q, write_en_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               transmit_q, transmit_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;

  logic [OPC_W-1:0]   opc;
  logic [AW-1:0]      op_addr;
  logic [DW-1:0]      alu_b;
  logic [DW-1:0]      alu_sum;
  logic               alu_carry;
  logic               alu_zero;

  assign opc     = opcode_q[OPC_W-1:0];
  assign op_addr = AW'(operand_q);

  // Same adder serves INCA (b=1) and ADD (b=memory operand, only used in MLOAD).
  assign alu_b = (state_q == ST_MLOAD) ? dread : DW'(1);

  accum_cpu_alu #(
    .DW (DW)
  ) u_alu (
    .a     (acc_q),
    .b     (alu_b),
    .sum   (alu_sum),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    z_d        = z_q;
    c_d        = c_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    cnt_d      = cnt_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    dwrite_d   = dwrite_q;
    tx_byte_d  = tx_byte_q;
    running_d  = running_q;
    write_en_d = 1'b0;
    transmit_d = 1'b0;
    halted_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d      = start_addr;
          running_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        raddr_d = pc_q;
        if (NO_WAIT) begin
          state_d = ST_OPLOAD;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 8'd0) state_d = ST_OPLOAD;
        else               cnt_d   = cnt_q - 8'd1;
      end

      ST_OPLOAD: begin
        opcode_d = dread;
        pc_d     = pc_q + 1'b1;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        if (opcode_q[TB]) begin
          raddr_d = pc_q;
          if (NO_WAIT) begin
            state_d = ST_OPLOAD2;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT2;
          end
        end else begin
          case (opc)
            OP_HLT: begin
              halted_d  = 1'b1;
              running_d = 1'b0;
              state_d   = ST_IDLE;
            end
            OP_OUTA:          state_d = ST_OUT;
            OP_CLRA, OP_INCA: state_d = ST_EXEC1;
            default:          state_d = ST_FETCH;
          endcase
        end
      end

      ST_EXEC1: begin
        if (opc == OP_CLRA) begin
          acc_d = '0;
          z_d   = 1'b1;
          c_d   = 1'b0;
        end else begin
          acc_d = alu_sum;
          z_d   = alu_zero;
          c_d   = alu_carry;
        end
        state_d = ST_FETCH;
      end

      ST_OUT: begin
        if (!tx_busy) begin
          tx_byte_d  = acc_q[7:0];
          transmit_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_WAIT2: begin
        if (cnt_q == 8'd0) state_d = ST_OPLOAD2;
        else               cnt_d   = cnt_q - 8'd1;
      end

      ST_OPLOAD2: begin
        operand_d = dread;
        pc_d      = pc_q + 1'b1;
        state_d   = ST_EXEC2;
      end

      ST_EXEC2: begin
        state_d = ST_FETCH;
        case (opc)
          OP_LDI: begin
            acc_d = operand_q;
            z_d   = (operand_q == '0);
          end
          OP_JMP: pc_d = op_addr;
          OP_JZ:  if (z_q) pc_d = op_addr;
          OP_JC:  if (c_q) pc_d = op_addr;
          OP_STA: begin
            waddr_d    = op_addr;
            dwrite_d   = acc_q;
            write_en_d = 1'b1;
          end
          OP_LDA, OP_ADD: begin
            raddr_d = op_addr;
            if (NO_WAIT) begin
              state_d = ST_MLOAD;
            end else begin
              cnt_d   = WAIT_INIT;
              state_d = ST_MWAIT;
            end
          end
          default: ;
        endcase
      end

      ST_MWAIT: begin
        if (cnt_q == 8'd0) state_d = ST_MLOAD;
        else               cnt_d   = cnt_q - 8'd1;
      end

      ST_MLOAD: begin
        if (opc == OP_LDA) begin
          acc_d = dread;
          z_d   = (dread == '0);
        end else begin
          acc_d = alu_sum;
          z_d   = alu_zero;
          c_d   = alu_carry;
        end
        state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      z_q        <= 1'b1;
      c_q        <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      cnt_q      <= 8'd0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      dwrite_q   <= '0;
      write_en_q <= 1'b0;
      tx_byte_q  <= 8'd0;
      transmit_q <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      z_q        <= z_d;
      c_q        <= c_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      dwrite_q   <= dwrite_d;
      write_en_q <= write_en_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
    end
  end

  assign raddr    = raddr_q;
  assign waddr    = waddr_q;
  assign dwrite   = dwrite_q;
  assign write_en = write_en_q;
  assign tx_byte  = tx_byte_q;
  assign transmit = transmit_q;
  assign running  = running_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_accum_cpu_p.sv
// Bench for accum_cpu_p: three cores (RD_LAT 2, 1, 3), each with its own RAM model, run
// a table of directed programs plus hand-written busy-UART and mid-instruction reset sequences.
module tb_accum_cpu_p;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       tx_busy;
  logic [8:0] start_addr;
  logic       clr;
  logic       mon_clr;
  logic       ld_en;
  logic [8:0] ld_addr;
  logic [7:0] ld_data;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

    logic [8:0] raddr, waddr;
    logic [7:0] dread, dwrite, tx_byte;
    logic       write_en, transmit, running, halted;
    logic [7:0] mem [512];
    int         ntx, nwe, nhalt;
    logic [7:0] txb, wd;
    logic [8:0] wa;

    accum_cpu_p #(
      .DW     (8),
      .AW     (9),
      .RD_LAT (LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .raddr      (raddr),
      .dread      (dread),
      .waddr      (waddr),
      .dwrite     (dwrite),
      .write_en   (write_en),
      .tx_byte    (tx_byte),
      .transmit   (transmit),
      .tx_busy    (tx_busy),
      .running    (running),
      .halted     (halted)
    );

    always @(posedge clk) begin
      if (clr) begin
        for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      end else begin
        if (ld_en)    mem[ld_addr] <= ld_data;
        if (write_en) mem[waddr]   <= dwrite;
      end
    end

    // Read data appears LAT-1 cycles after raddr changes.
    if (LAT == 1) begin : g_l1
      assign dread = mem[raddr];
    end else begin : g_ln
      logic [7:0] pipe [LAT-1];
      always @(posedge clk) begin
        pipe[0] <= mem[raddr];
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
      end
      assign dread = pipe[LAT-2];
    end

    always @(posedge clk) begin
      if (mon_clr) begin
        ntx   <= 0;
        nwe   <= 0;
        nhalt <= 0;
        txb   <= 8'h00;
        wd    <= 8'h00;
        wa    <= 9'h000;
      end else begin
        if (transmit) begin
          ntx <= ntx + 1;
          txb <= tx_byte;
        end
        if (write_en) begin
          nwe <= nwe + 1;
          wa  <= waddr;
          wd  <= dwrite;
        end
        if (halted) nhalt <= nhalt + 1;
      end
    end
  end

  typedef struct {
    logic [8:0]  start;
    logic [63:0] prog;   // byte 0 in bits 63:56
    int          n;
    logic [8:0]  xa0;
    logic [7:0]  xd0;
    logic [8:0]  xa1;
    logic [7:0]  xd1;
    int          tx_n;
    logic [7:0]  tx_b;
    int          we_n;
    logic [8:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  acc;
    logic        z;
    logic        c;
    logic [8:0]  pc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    clr     = 1'b1;
    mon_clr = 1'b1;
    start   = 1'b0;
    tx_busy = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 9'h000;
    ld_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    clr     = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic load(input logic [8:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic pulse_start(input logic [8:0] a);
    start_addr = a;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (g_i[0].nhalt > 0 && g_i[1].nhalt > 0 && g_i[2].nhalt > 0) begin
        done = 1'b1;
        break;
      end
    end
    check({name, " halt_reached"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_inst(input int vi, input int lat, input vec_t v,
                            input int ntx, input logic [7:0] txb, input int nwe,
                            input logic [8:0] wa, input logic [7:0] wd, input int nhalt,
                            input logic [7:0] acc, input logic z, input logic c,
                            input logic [8:0] pc, input logic run);
    string p;
    p = $sformatf("v%0d_lat%0d", vi, lat);
    check({p, " tx_count"}, ntx, v.tx_n);
    if (v.tx_n > 0) check({p, " tx_byte"}, txb, v.tx_b);
    check({p, " we_count"}, nwe, v.we_n);
    if (v.we_n > 0) begin
      check({p, " waddr"}, wa, v.wa);
      check({p, " dwrite"}, wd, v.wd);
    end
    check({p, " halt_count"}, nhalt, 1);
    check({p, " acc"}, acc, v.acc);
    check({p, " zflag"}, z, v.z);
    check({p, " cflag"}, c, v.c);
    check({p, " pc"}, pc, v.pc);
    check({p, " running"}, run, 1'b0);
  endtask

  initial begin
    //         start   prog                    n  xa0     xd0    xa1     xd1    txn txb   wen wa      wd     acc    z     c     pc
    vecs[0] = '{9'h010, 64'h8041_0100_0000_0000, 4, 9'h100, 8'h00, 9'h101, 8'h00, 1, 8'h41, 0, 9'h000, 8'h00, 8'h41, 1'b0, 1'b0, 9'h014};
    vecs[1] = '{9'h010, 64'h80FF_8620_8930_0000, 6, 9'h020, 8'h01, 9'h030, 8'h00, 0, 8'h00, 0, 9'h000, 8'h00, 8'h00, 1'b1, 1'b1, 9'h031};
    vecs[2] = '{9'h010, 64'h805A_8540_8440_0000, 7, 9'h100, 8'h00, 9'h101, 8'h00, 0, 8'h00, 1, 9'h040, 8'h5A, 8'h5A, 1'b0, 1'b0, 9'h017};
    vecs[3] = '{9'h1FF, 64'h7F00_0000_0000_0000, 2, 9'h100, 8'h00, 9'h101, 8'h00, 0, 8'h00, 0, 9'h000, 8'h00, 8'h00, 1'b1, 1'b0, 9'h001};
    vecs[4] = '{9'h010, 64'h80FE_0303_8A20_0100, 8, 9'h020, 8'h01, 9'h021, 8'h00, 1, 8'h00, 0, 9'h000, 8'h00, 8'h00, 1'b1, 1'b1, 9'h022};
    vecs[5] = '{9'h010, 64'h80FF_8620_8930_0102, 8, 9'h020, 8'h05, 9'h018, 8'h00, 1, 8'h04, 0, 9'h000, 8'h00, 8'h00, 1'b1, 1'b0, 9'h019};
    vecs[6] = '{9'h010, 64'h8001_8514_0000_0000, 6, 9'h100, 8'h00, 9'h101, 8'h00, 1, 8'h01, 1, 9'h014, 8'h01, 8'h01, 1'b0, 1'b0, 9'h016};
    vecs[7] = '{9'h010, 64'h8B01_0580_3388_4000, 8, 9'h040, 8'h01, 9'h041, 8'h00, 1, 8'h33, 0, 9'h000, 8'h00, 8'h33, 1'b0, 1'b0, 9'h042};

    start_addr = 9'h000;

    // Reset state; start coinciding with rst must be ignored.
    do_reset();
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst raddr",    g_i[0].raddr, 0);
    check("rst waddr",    g_i[0].waddr, 0);
    check("rst dwrite",   g_i[0].dwrite, 0);
    check("rst tx_byte",  g_i[0].tx_byte, 0);
    check("rst write_en", g_i[0].write_en, 0);
    check("rst transmit", g_i[0].transmit, 0);
    check("rst halted",   g_i[0].halted, 0);
    check("rst running",  g_i[0].running, 0);
    check("rst acc",      g_i[0].u_dut.acc_q, 0);
    check("rst zflag",    g_i[0].u_dut.z_q, 1);
    check("rst cflag",    g_i[0].u_dut.c_q, 0);
    check("rst pc",       g_i[0].u_dut.pc_q, 0);

    for (int vi = 0; vi < 8; vi++) begin
      do_reset();
      load(vecs[vi].xa0, vecs[vi].xd0);
      load(vecs[vi].xa1, vecs[vi].xd1);
      for (int i = 0; i < vecs[vi].n; i++) begin
        load(vecs[vi].start + 9'(i), vecs[vi].prog[63-8*i -: 8]);
      end
      rst = 1'b0;
      @(negedge clk);
      pulse_start(vecs[vi].start);
      wait_halt(600, $sformatf("v%0d", vi));
      check_inst(vi, 2, vecs[vi], g_i[0].ntx, g_i[0].txb, g_i[0].nwe, g_i[0].wa, g_i[0].wd,
                 g_i[0].nhalt, g_i[0].u_dut.acc_q, g_i[0].u_dut.z_q, g_i[0].u_dut.c_q,
                 g_i[0].u_dut.pc_q, g_i[0].running);
      check_inst(vi, 1, vecs[vi], g_i[1].ntx, g_i[1].txb, g_i[1].nwe, g_i[1].wa, g_i[1].wd,
                 g_i[1].nhalt, g_i[1].u_dut.acc_q, g_i[1].u_dut.z_q, g_i[1].u_dut.c_q,
                 g_i[1].u_dut.pc_q, g_i[1].running);
      check_inst(vi, 3, vecs[vi], g_i[2].ntx, g_i[2].txb, g_i[2].nwe, g_i[2].wa, g_i[2].wd,
                 g_i[2].nhalt, g_i[2].u_dut.acc_q, g_i[2].u_dut.z_q, g_i[2].u_dut.c_q,
                 g_i[2].u_dut.pc_q, g_i[2].running);
    end

    // OUTA against a busy UART; a start pulse mid-run must be ignored.
    do_reset();
    load(9'h010, 8'h80);
    load(9'h011, 8'h41);
    load(9'h012, 8'h01);
    load(9'h013, 8'h00);
    rst     = 1'b0;
    tx_busy = 1'b1;
    @(negedge clk);
    pulse_start(9'h010);
    repeat (4) @(negedge clk);
    pulse_start(9'h000);
    repeat (14) @(negedge clk);
    check("busy running",         g_i[0].running, 1);
    check("busy no_transmit_yet", g_i[0].ntx, 0);
    check("busy transmit_low",    g_i[0].transmit, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy transmit_pulse",  g_i[0].transmit, 1);
    check("busy tx_byte",         g_i[0].tx_byte, 8'h41);
    @(negedge clk);
    check("busy transmit_end",    g_i[0].transmit, 0);
    wait_halt(600, "busy");
    check("busy tx_count",        g_i[0].ntx, 1);
    check("busy pc",              g_i[0].u_dut.pc_q, 9'h014);

    // rst in the middle of ADD: everything back to reset, no later write or transmit.
    do_reset();
    load(9'h020, 8'h01);
    load(9'h010, 8'h80);
    load(9'h011, 8'hFF);
    load(9'h012, 8'h86);
    load(9'h013, 8'h20);
    load(9'h014, 8'h85);
    load(9'h015, 8'h50);
    load(9'h016, 8'h01);
    load(9'h017, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(9'h010);
    repeat (14) @(negedge clk);
    check("midadd running", g_i[0].running, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midadd raddr",    g_i[0].raddr, 0);
    check("midadd waddr",    g_i[0].waddr, 0);
    check("midadd dwrite",   g_i[0].dwrite, 0);
    check("midadd tx_byte",  g_i[0].tx_byte, 0);
    check("midadd write_en", g_i[0].write_en, 0);
    check("midadd transmit", g_i[0].transmit, 0);
    check("midadd halted",   g_i[0].halted, 0);
    check("midadd running0", g_i[0].running, 0);
    check("midadd acc",      g_i[0].u_dut.acc_q, 0);
    check("midadd zflag",    g_i[0].u_dut.z_q, 1);
    check("midadd cflag",    g_i[0].u_dut.c_q, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midadd we_count",    g_i[0].nwe, 0);
    check("midadd tx_count",    g_i[0].ntx, 0);
    check("midadd halt_count",  g_i[0].nhalt, 0);
    check("midadd stays_idle",  g_i[0].running, 0);
    check("midadd mem50",       g_i[0].mem[9'h050], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
